wb_reg_pipe: RTL

- Single-clock Wishbone (classic, non-pipelined) register slice with configurable request delay (STAGES) and a registered response path.
- Sits between a master and a slave/interconnect to break timing paths, and optionally adds a response watchdog.
- Generalises the plain register slice with:
  - multi-stage request delay;
  - cycle-abort handling;
  - timeout-to-error conversion.

---
 rtl/wb_reg_pipe.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_reg_pipe.sv
// Wishbone classic register slice: STAGES-cycle request delay, registered response, cycle-abort handling.
// Optional response watchdog (timeout -> m_err_o) is built when WB_REG_PIPE_TIMEOUT_EN is defined.
module wb_reg_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter int STAGES       = 1,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  input  logic                    m_we_i,
  input  logic [SELECT_WIDTH-1:0] m_sel_i,
  input  logic                    m_stb_i,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  output logic                    m_rty_o,
  input  logic                    m_cyc_i,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic                    s_cyc_o
);

  localparam int DCW = (STAGES > 1) ? $clog2(STAGES) : 1;

  if (STAGES < 1 || STAGES > 8 || TIMEOUT < 2) begin : g_param_chk
    $error("wb_reg_pipe: STAGES must be 1..8 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state, state_d;
  logic [DCW-1:0]          dly_cnt, dly_cnt_d;
  logic                    req_we, req_we_d;
  logic [DATA_WIDTH-1:0]   m_dat_d;
  logic                    m_ack_d, m_err_d, m_rty_d;
  logic [ADDR_WIDTH-1:0]   s_adr_d;
  logic [DATA_WIDTH-1:0]   s_dat_d;
  logic [SELECT_WIDTH-1:0] s_sel_d;
  logic                    s_we_d, s_stb_d, s_cyc_d;
  logic                    slv_resp;

`ifdef WB_REG_PIPE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0]          to_cnt, to_cnt_d;
`endif

  assign slv_resp = s_ack_i | s_err_i | s_rty_i;

  always_comb begin
    state_d   = state;
    dly_cnt_d = dly_cnt;
    req_we_d  = req_we;
    m_dat_d   = m_dat_o;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    m_rty_d   = 1'b0;
    s_adr_d   = s_adr_o;
    s_dat_d   = s_dat_o;
    s_sel_d   = s_sel_o;
    s_we_d    = s_we_o;
    s_stb_d   = s_stb_o;
    s_cyc_d   = s_cyc_o;
`ifdef WB_REG_PIPE_TIMEOUT_EN
    to_cnt_d  = to_cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (!m_cyc_i) begin
          s_cyc_d = 1'b0;
        end else if (m_stb_i) begin
          s_adr_d  = m_adr_i;
          s_dat_d  = m_dat_i;
          s_sel_d  = m_sel_i;
          req_we_d = m_we_i;
          if (STAGES > 1) begin
            state_d   = ST_DELAY;
            dly_cnt_d = DCW'(STAGES - 1);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_DELAY: begin
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
          s_stb_d = 1'b0;
          s_cyc_d = 1'b0;
          s_we_d  = 1'b0;
        end else begin
          dly_cnt_d = dly_cnt - DCW'(1);
          if (dly_cnt == DCW'(1)) begin
            state_d = ST_WAIT;
          end
        end
      end

      // First WAIT cycle launches the strobe; responses count only once it is up.
      ST_WAIT: begin
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
          s_stb_d = 1'b0;
          s_cyc_d = 1'b0;
          s_we_d  = 1'b0;
        end else if (!s_stb_o) begin
          s_stb_d = 1'b1;
          s_cyc_d = 1'b1;
          s_we_d  = req_we;
`ifdef WB_REG_PIPE_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else if (slv_resp) begin
          state_d = ST_RESP;
          s_stb_d = 1'b0;
          s_we_d  = 1'b0;
          m_dat_d = s_dat_i;
          m_ack_d = s_ack_i;
          m_err_d = s_err_i;
          m_rty_d = s_rty_i;
        end
`ifdef WB_REG_PIPE_TIMEOUT_EN
        else if (to_cnt == TCW'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          s_stb_d = 1'b0;
          s_cyc_d = 1'b0;
          s_we_d  = 1'b0;
          m_dat_d = '0;
          m_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt + TCW'(1);
        end
`endif
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        m_dat_d = '0;
        if (!m_cyc_i) begin
          s_cyc_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      dly_cnt <= '0;
      req_we  <= 1'b0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
      s_we_o  <= 1'b0;
      s_stb_o <= 1'b0;
      s_cyc_o <= 1'b0;
`ifdef WB_REG_PIPE_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      state   <= state_d;
      dly_cnt <= dly_cnt_d;
      req_we  <= req_we_d;
      m_dat_o <= m_dat_d;
      m_ack_o <= m_ack_d;
      m_err_o <= m_err_d;
      m_rty_o <= m_rty_d;
      s_adr_o <= s_adr_d;
      s_dat_o <= s_dat_d;
      s_sel_o <= s_sel_d;
      s_we_o  <= s_we_d;
      s_stb_o <= s_stb_d;
      s_cyc_o <= s_cyc_d;
`ifdef WB_REG_PIPE_TIMEOUT_EN
      to_cnt  <= to_cnt_d;
`endif
    end
  end

endmodule
